// File: rtl/conv_layer_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_layer_sched_if
//  Purpose  : Bundles every signal of the layer scheduler except clk and rst.
//             Groups: layer descriptor handshake, core configuration and
//             strobes, ifm/wgt memory read requests, ofm write stream, and
//             status flags.
//  Modports : master - the scheduler itself
//             slave  - the environment (descriptor source, core, memories)
//  Revision : 1.0  initial release
// ============================================================================
interface conv_layer_sched_if #(
    parameter int ADDR_W = 16,
    parameter int OFM_W  = 25
);
    // layer descriptor
    logic              cfg_valid;
    logic              cfg_ready;
    logic [31:0]       cfg_ci;
    logic [31:0]       cfg_co;
    logic [31:0]       cfg_tiles;
    logic [ADDR_W-1:0] cfg_ifm_base;
    logic [ADDR_W-1:0] cfg_wgt_base;
    logic [ADDR_W-1:0] cfg_ofm_base;
    // convolution core
    logic              acc_start_conv;
    logic [31:0]       acc_cfg_ci;
    logic [31:0]       acc_cfg_co;
    logic [31:0]       acc_tile_num;
    logic              acc_ifm_read;
    logic              acc_wgt_read;
    logic [OFM_W-1:0]  acc_ofm_port0;
    logic [OFM_W-1:0]  acc_ofm_port1;
    logic              acc_ofm_port0_v;
    logic              acc_ofm_port1_v;
    logic              acc_end_op;
    logic              acc_stall;
    // memory read requests
    logic              ifm_mem_en;
    logic [ADDR_W-1:0] ifm_mem_addr;
    logic              wgt_mem_en;
    logic [ADDR_W-1:0] wgt_mem_addr;
    // output write stream
    logic              ofm_wr_valid;
    logic              ofm_wr_ready;
    logic [ADDR_W-1:0] ofm_wr_addr;
    logic [OFM_W-1:0]  ofm_wr_data;
    // status
    logic              busy;
    logic              done;
    logic              ovf_err;

    modport master (
        input  cfg_valid, cfg_ci, cfg_co, cfg_tiles,
               cfg_ifm_base, cfg_wgt_base, cfg_ofm_base,
               acc_ifm_read, acc_wgt_read,
               acc_ofm_port0, acc_ofm_port1, acc_ofm_port0_v, acc_ofm_port1_v,
               acc_end_op, ofm_wr_ready,
        output cfg_ready, acc_start_conv, acc_cfg_ci, acc_cfg_co, acc_tile_num,
               acc_stall, ifm_mem_en, ifm_mem_addr, wgt_mem_en, wgt_mem_addr,
               ofm_wr_valid, ofm_wr_addr, ofm_wr_data, busy, done, ovf_err
    );

    modport slave (
        output cfg_valid, cfg_ci, cfg_co, cfg_tiles,
               cfg_ifm_base, cfg_wgt_base, cfg_ofm_base,
               acc_ifm_read, acc_wgt_read,
               acc_ofm_port0, acc_ofm_port1, acc_ofm_port0_v, acc_ofm_port1_v,
               acc_end_op, ofm_wr_ready,
        input  cfg_ready, acc_start_conv, acc_cfg_ci, acc_cfg_co, acc_tile_num,
               acc_stall, ifm_mem_en, ifm_mem_addr, wgt_mem_en, wgt_mem_addr,
               ofm_wr_valid, ofm_wr_addr, ofm_wr_data, busy, done, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/conv_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : conv_layer_sched
//  Purpose  : Layer-level controller for the convolution core. Accepts one
//             layer descriptor, pulses start to the core, turns the core's
//             ifm/wgt read strobes into sequential read addresses, and merges
//             the core's two output ports into one ordered write stream via a
//             dual-push FIFO, stalling the core as that FIFO fills.
//  Ports    : clk  - clock
//             rst  - asynchronous active-high reset
//             bus  - conv_layer_sched_if.master (descriptor, core, memories,
//                    write stream, status)
//  Revision : 1.0  initial release
// ============================================================================
module conv_layer_sched #(
    parameter int ADDR_W      = 16,
    parameter int OFM_W       = 25,
    parameter int OFIFO_DEPTH = 8,
    parameter int OFIFO_AFULL = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    conv_layer_sched_if.master     bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int c_PTR_W = $clog2(OFIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_AFULL = c_CNT_W'(OFIFO_AFULL);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               r_cfg_ready;

    logic [31:0]        r_ci;
    logic [31:0]        r_co;
    logic [31:0]        r_tiles;
    logic [ADDR_W-1:0]  r_ifm_ptr;
    logic [ADDR_W-1:0]  r_wgt_ptr;
    logic [ADDR_W-1:0]  r_ofm_base;
    logic [ADDR_W-1:0]  r_wr_idx;

    logic [OFM_W-1:0]   r_mem [OFIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_stall;
    logic               r_ovf;

    logic               w_accept;
    logic               w_ifm_en;
    logic               w_wgt_en;
    logic               w_ofm_valid;
    logic               w_pop;
    logic               w_push0;
    logic               w_push1;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_drop;
    int                 w_room;
    logic [c_PTR_W-1:0] w_wr1_idx;
    logic [c_CNT_W-1:0] w_cnt_next;

    // cfg_ready is registered so it is low while rst is held and only rises
    // once the FSM is settled in IDLE.
    assign w_accept    = bus.cfg_valid & r_cfg_ready;
    assign w_ofm_valid = (r_count != '0);
    assign w_pop       = w_ofm_valid & bus.ofm_wr_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cfg_ready <= (w_state_next == S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_next = (bus.cfg_tiles == 32'd0) ? S_DONE : S_START;
            end
            S_START: w_state_next = S_RUN;
            S_RUN: begin
                if (bus.acc_end_op)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // an output valid this cycle is a write still in flight
                if (!w_ofm_valid && !bus.acc_ofm_port0_v && !bus.acc_ofm_port1_v)
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ifm_en           = (r_state == S_RUN) & bus.acc_ifm_read & ~r_stall;
        w_wgt_en           = (r_state == S_RUN) & bus.acc_wgt_read & ~r_stall;
        bus.cfg_ready      = r_cfg_ready;
        bus.acc_start_conv = (r_state == S_START);
        bus.busy           = (r_state != S_IDLE);
        bus.done           = (r_state == S_DONE);
        bus.ifm_mem_en     = w_ifm_en;
        bus.wgt_mem_en     = w_wgt_en;
        bus.ifm_mem_addr   = r_ifm_ptr;
        bus.wgt_mem_addr   = r_wgt_ptr;
        bus.acc_cfg_ci     = r_ci;
        bus.acc_cfg_co     = r_co;
        bus.acc_tile_num   = r_tiles;
        bus.acc_stall      = r_stall;
        bus.ofm_wr_valid   = w_ofm_valid;
        bus.ofm_wr_addr    = r_ofm_base + r_wr_idx;
        // head is masked when empty so stale entries never reach the port
        bus.ofm_wr_data    = w_ofm_valid ? r_mem[r_rptr] : '0;
        bus.ovf_err        = r_ovf;
    end

    // ------------------------------------------------------------------
    // Descriptor latch and address pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ci       <= '0;
            r_co       <= '0;
            r_tiles    <= '0;
            r_ifm_ptr  <= '0;
            r_wgt_ptr  <= '0;
            r_ofm_base <= '0;
            r_wr_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_ci       <= bus.cfg_ci;
                r_co       <= bus.cfg_co;
                r_tiles    <= bus.cfg_tiles;
                r_ifm_ptr  <= bus.cfg_ifm_base;
                r_wgt_ptr  <= bus.cfg_wgt_base;
                r_ofm_base <= bus.cfg_ofm_base;
                r_wr_idx   <= '0;
            end else begin
                if (w_ifm_en) r_ifm_ptr <= r_ifm_ptr + ADDR_W'(1);
                if (w_wgt_en) r_wgt_ptr <= r_wgt_ptr + ADDR_W'(1);
                if (w_pop)    r_wr_idx  <= r_wr_idx + ADDR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Dual-push output FIFO. Port0 takes the first free slot; port1 takes
    // the slot after it when both push, so port0 data is drained first.
    // Room counts the slot freed by a same-cycle pop.
    // ------------------------------------------------------------------
    always_comb begin
        w_push0    = bus.acc_ofm_port0_v & (r_state != S_IDLE);
        w_push1    = bus.acc_ofm_port1_v & (r_state != S_IDLE);
        w_room     = OFIFO_DEPTH - int'(r_count) + int'(w_pop);
        w_acc0     = w_push0 & (w_room >= 1);
        w_acc1     = w_push1 & (w_room >= 1 + int'(w_acc0));
        w_drop     = (w_push0 & ~w_acc0) | (w_push1 & ~w_acc1);
        w_wr1_idx  = r_wptr + c_PTR_W'(w_acc0);
        w_cnt_next = r_count + c_CNT_W'(w_acc0) + c_CNT_W'(w_acc1) - c_CNT_W'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OFIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_stall <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_acc0) r_mem[r_wptr]    <= bus.acc_ofm_port0;
            if (w_acc1) r_mem[w_wr1_idx] <= bus.acc_ofm_port1;
            r_wptr  <= r_wptr + c_PTR_W'(w_acc0) + c_PTR_W'(w_acc1);
            if (w_pop) r_rptr <= r_rptr + c_PTR_W'(1);
            r_count <= w_cnt_next;
            // stall follows the occupancy seen this cycle, one cycle late
            r_stall <= (r_count >= c_AFULL);
            r_ovf   <= r_ovf | w_drop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_layer_sched
//  Purpose  : Self-checking bench for conv_layer_sched. Expected writes and
//             read addresses are queued by the stimulus; a negedge monitor
//             pops and compares whenever the DUT presents a transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_layer_sched;

    localparam int ADDR_W = 16;
    localparam int OFM_W  = 25;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [OFM_W-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_layer_sched_if #(.ADDR_W(ADDR_W), .OFM_W(OFM_W)) bus();

    conv_layer_sched #(
        .ADDR_W(ADDR_W), .OFM_W(OFM_W), .OFIFO_DEPTH(8), .OFIFO_AFULL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int cnt_start = 0;
    int cnt_done  = 0;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_ifm[$];
    logic [ADDR_W-1:0] exp_wgt[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // ------------------------------------------------------------------
    // Monitor: inputs only change just after posedge, so negedge sees the
    // values that will be captured at the next posedge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        wr_t               e;
        logic [ADDR_W-1:0] a;
        if (!rst) begin
            if (bus.ofm_wr_valid && bus.ofm_wr_ready) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got addr %h data %h expected none", bus.ofm_wr_addr, bus.ofm_wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(bus.ofm_wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(bus.ofm_wr_data), 32'(e.data));
                end
            end
            if (bus.ifm_mem_en) begin
                if (exp_ifm.size() == 0) begin
                    n_checks++;
                    $display("FAIL ifm_unexpected: got addr %h expected none", bus.ifm_mem_addr);
                end else begin
                    a = exp_ifm.pop_front();
                    chk("ifm_addr", 32'(bus.ifm_mem_addr), 32'(a));
                end
            end
            if (bus.wgt_mem_en) begin
                if (exp_wgt.size() == 0) begin
                    n_checks++;
                    $display("FAIL wgt_unexpected: got addr %h expected none", bus.wgt_mem_addr);
                end else begin
                    a = exp_wgt.pop_front();
                    chk("wgt_addr", 32'(bus.wgt_mem_addr), 32'(a));
                end
            end
            if (bus.acc_start_conv) cnt_start++;
            if (bus.done)           cnt_done++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [OFM_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic send_cfg(input logic [31:0] ci, input logic [31:0] co, input logic [31:0] tiles,
                            input logic [ADDR_W-1:0] ifm, input logic [ADDR_W-1:0] wgt,
                            input logic [ADDR_W-1:0] ofm);
        logic ok;
        ok = 1'b0;
        bus.cfg_ci = ci;  bus.cfg_co = co;  bus.cfg_tiles = tiles;
        bus.cfg_ifm_base = ifm;  bus.cfg_wgt_base = wgt;  bus.cfg_ofm_base = ofm;
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cfg_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.cfg_valid = 1'b0;
        chk("cfg_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string nm, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    task automatic end_op;
        bus.acc_end_op = 1'b1;
        tick();
        bus.acc_end_op = 1'b0;
    endtask

    initial begin
        int st0;
        bus.cfg_valid = 0;  bus.cfg_ci = 0;  bus.cfg_co = 0;  bus.cfg_tiles = 0;
        bus.cfg_ifm_base = 0;  bus.cfg_wgt_base = 0;  bus.cfg_ofm_base = 0;
        bus.acc_ifm_read = 0;  bus.acc_wgt_read = 0;
        bus.acc_ofm_port0 = 0;  bus.acc_ofm_port1 = 0;
        bus.acc_ofm_port0_v = 0;  bus.acc_ofm_port1_v = 0;
        bus.acc_end_op = 0;  bus.ofm_wr_ready = 1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wr_valid", 32'(bus.ofm_wr_valid), 0);
        chk("rst_stall", 32'(bus.acc_stall), 0);
        chk("rst_ovf", 32'(bus.ovf_err), 0);
        rst = 1'b0;
        tick();
        chk("idle_cfg_ready", 32'(bus.cfg_ready), 1);

        // ---------------- 1: basic layer ----------------
        send_cfg(3, 16, 1, 16'h0100, 16'h0200, 16'h0400);
        chk("t1_start", 32'(bus.acc_start_conv), 1);
        chk("t1_cfg_ci", bus.acc_cfg_ci, 3);
        chk("t1_cfg_co", bus.acc_cfg_co, 16);
        chk("t1_tiles", bus.acc_tile_num, 1);
        chk("t1_busy", 32'(bus.busy), 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            exp_ifm.push_back(16'h0100 + 16'(i));
            if (i < 3) exp_wgt.push_back(16'h0200 + 16'(i));
            bus.acc_ifm_read = 1'b1;
            bus.acc_wgt_read = (i < 3);
            tick();
        end
        bus.acc_ifm_read = 0;  bus.acc_wgt_read = 0;
        for (int i = 0; i < 6; i++) begin
            push_wr(16'h0400 + 16'(i), 25'(100 + i));
            bus.acc_ofm_port0 = 25'(100 + i);
            bus.acc_ofm_port0_v = 1'b1;
            tick();
        end
        bus.acc_ofm_port0_v = 0;
        end_op();
        wait_done("t1_done", 30);
        chk("t1_busy_in_done", 32'(bus.busy), 1);
        tick();
        chk("t1_busy_after", 32'(bus.busy), 0);
        chk("t1_done_single", 32'(bus.done), 0);
        chk("t1_start_count", 32'(cnt_start), 1);
        chk("t1_done_count", 32'(cnt_done), 1);
        chk("t1_wr_left", 32'(exp_wr.size()), 0);

        // ---------------- 2: dual-port ordering ----------------
        send_cfg(1, 1, 2, 16'h0000, 16'h0000, 16'h0500);
        tick();
        push_wr(16'h0500, 25'd5);
        push_wr(16'h0501, 25'd7);
        push_wr(16'h0502, 25'd9);
        bus.acc_ofm_port0 = 25'd5;  bus.acc_ofm_port0_v = 1;
        bus.acc_ofm_port1 = 25'd7;  bus.acc_ofm_port1_v = 1;
        tick();
        bus.acc_ofm_port0_v = 0;
        bus.acc_ofm_port1 = 25'd9;
        tick();
        bus.acc_ofm_port1_v = 0;
        end_op();
        wait_done("t2_done", 20);
        tick();
        chk("t2_wr_left", 32'(exp_wr.size()), 0);

        // ---------------- 3: backpressure ----------------
        send_cfg(2, 2, 1, 16'h0300, 16'h0000, 16'h0600);
        tick();
        bus.ofm_wr_ready = 0;
        bus.acc_ifm_read = 1;
        exp_ifm.push_back(16'h0300);
        push_wr(16'h0600, 25'h11);
        push_wr(16'h0601, 25'h22);
        bus.acc_ofm_port0 = 25'h11;  bus.acc_ofm_port1 = 25'h22;
        bus.acc_ofm_port0_v = 1;  bus.acc_ofm_port1_v = 1;
        tick();
        exp_ifm.push_back(16'h0301);
        push_wr(16'h0602, 25'h33);
        push_wr(16'h0603, 25'h44);
        bus.acc_ofm_port0 = 25'h33;  bus.acc_ofm_port1 = 25'h44;
        tick();
        bus.acc_ofm_port0_v = 0;  bus.acc_ofm_port1_v = 0;
        exp_ifm.push_back(16'h0302);
        chk("t3_stall_at_4", 32'(bus.acc_stall), 0);
        tick();
        chk("t3_stall_after_4", 32'(bus.acc_stall), 1);
        chk("t3_ifm_en_stalled", 32'(bus.ifm_mem_en), 0);
        tick();
        chk("t3_ifm_en_stalled2", 32'(bus.ifm_mem_en), 0);
        chk("t3_wr_valid", 32'(bus.ofm_wr_valid), 1);
        bus.acc_ifm_read = 0;
        bus.ofm_wr_ready = 1;
        repeat (8) tick();
        chk("t3_stall_release", 32'(bus.acc_stall), 0);
        chk("t3_wr_left", 32'(exp_wr.size()), 0);
        chk("t3_ovf", 32'(bus.ovf_err), 0);
        end_op();
        wait_done("t3_done", 20);
        tick();

        // ---------------- 4: zero tiles ----------------
        st0 = cnt_start;
        send_cfg(4, 4, 0, 16'h0000, 16'h0000, 16'h0000);
        wait_done("t4_done_2cyc", 2);
        tick();
        chk("t4_no_start", 32'(cnt_start - st0), 0);
        chk("t4_cfg_ready", 32'(bus.cfg_ready), 1);

        // ---------------- 5: reset mid-RUN ----------------
        send_cfg(1, 1, 1, 16'h0AA0, 16'h0BB0, 16'h0700);
        tick();
        bus.ofm_wr_ready = 0;
        bus.acc_ofm_port0 = 25'h1;  bus.acc_ofm_port1 = 25'h2;
        bus.acc_ofm_port0_v = 1;  bus.acc_ofm_port1_v = 1;
        tick();
        bus.acc_ofm_port1_v = 0;  bus.acc_ofm_port0 = 25'h3;
        tick();
        bus.acc_ofm_port0_v = 0;
        chk("t5_fifo_filled", 32'(bus.ofm_wr_valid), 1);
        bus.acc_ifm_read = 1;
        rst = 1'b1;
        #1;
        chk("t5_rst_wr_valid", 32'(bus.ofm_wr_valid), 0);
        chk("t5_rst_wr_addr", 32'(bus.ofm_wr_addr), 0);
        chk("t5_rst_wr_data", 32'(bus.ofm_wr_data), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("t5_rst_cfg_ci", bus.acc_cfg_ci, 0);
        chk("t5_rst_ifm_en", 32'(bus.ifm_mem_en), 0);
        chk("t5_rst_ifm_addr", 32'(bus.ifm_mem_addr), 0);
        bus.acc_ifm_read = 0;
        tick();
        rst = 1'b0;
        bus.ofm_wr_ready = 1;
        tick();
        chk("t5_fifo_empty", 32'(bus.ofm_wr_valid), 0);
        send_cfg(1, 1, 1, 16'h0800, 16'h0880, 16'h0900);
        tick();
        exp_ifm.push_back(16'h0800);
        exp_ifm.push_back(16'h0801);
        bus.acc_ifm_read = 1;
        repeat (2) tick();
        bus.acc_ifm_read = 0;
        push_wr(16'h0900, 25'h1234);
        bus.acc_ofm_port0 = 25'h1234;  bus.acc_ofm_port0_v = 1;
        tick();
        bus.acc_ofm_port0_v = 0;
        end_op();
        wait_done("t5_done", 20);
        tick();

        // ---------------- 6: address wrap ----------------
        send_cfg(1, 1, 1, 16'hFFFE, 16'h0000, 16'hFFFF);
        tick();
        exp_ifm.push_back(16'hFFFE);
        exp_ifm.push_back(16'hFFFF);
        exp_ifm.push_back(16'h0000);
        exp_ifm.push_back(16'h0001);
        bus.acc_ifm_read = 1;
        repeat (4) tick();
        bus.acc_ifm_read = 0;
        push_wr(16'hFFFF, 25'hA);
        push_wr(16'h0000, 25'hB);
        bus.acc_ofm_port0 = 25'hA;  bus.acc_ofm_port1 = 25'hB;
        bus.acc_ofm_port0_v = 1;  bus.acc_ofm_port1_v = 1;
        tick();
        bus.acc_ofm_port0_v = 0;  bus.acc_ofm_port1_v = 0;
        end_op();
        wait_done("t6_done", 20);
        tick();

        // ---------------- final ----------------
        chk("end_wr_left", 32'(exp_wr.size()), 0);
        chk("end_ifm_left", 32'(exp_ifm.size()), 0);
        chk("end_wgt_left", 32'(exp_wgt.size()), 0);
        chk("end_ovf", 32'(bus.ovf_err), 0);
        chk("end_idle", 32'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
